// File: rtl/hid_key_router.sv
// hid_key_router: collects an 8-byte HID boot keyboard report from a byte
// stream, picks one WASD keycode (player 1) and one arrow keycode (player 2),
// and presents both as outputs that only change on a frame_clk rising edge.
module hid_key_router #(
    parameter int REPORT_BYTES = 8,
    parameter int SYNC_STAGES  = 2,
    parameter bit FRAME_SYNC   = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       frame_clk,
    output logic [7:0] keycode_p1,
    output logic [7:0] keycode_p2,
    output logic       report_err
);

    localparam int NUM_SLOTS = 6;
    localparam int IDX_W     = $clog2(REPORT_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REPORT_BYTES - 1);
    localparam logic [2:0]       LAST_SLOT = 3'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_COLLECT,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              byte_idx;
    logic [2:0]                    scan_idx;
    logic [NUM_SLOTS-1:0][7:0]     slots;
    logic [7:0]                    cur_slot;
    logic [7:0]                    cand_p1, cand_p2;
    logic                          found_p1, found_p2;
    logic                          err_flag;
    logic                          xfer;

    assign xfer = byte_valid && byte_ready;

    function automatic logic is_p1_key(input logic [7:0] k);
        return (k == 8'h04) || (k == 8'h07) || (k == 8'h16) || (k == 8'h1A);
    endfunction

    function automatic logic is_p2_key(input logic [7:0] k);
        return (k >= 8'h4F) && (k <= 8'h52);
    endfunction

    // Slot under inspection during SCAN.
    always_comb begin
        cur_slot = 8'h00;
        for (int s = 0; s < NUM_SLOTS; s++)
            if (scan_idx == 3'(s)) cur_slot = slots[s];
    end

    // State register; reset state lets byte_ready rise one edge after release.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_RESET;
        else          state_q <= state_d;
    end

    // Next-state: collect all bytes, scan six slots, one commit cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:   state_d = S_COLLECT;
            S_COLLECT: if (xfer && byte_idx == LAST_IDX) state_d = S_SCAN;
            S_SCAN:    if (scan_idx == LAST_SLOT) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_COLLECT;
            default:   state_d = S_RESET;
        endcase
    end

    // Ready and error pulse registered off next state so both are clean flops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            byte_ready <= 1'b0;
            report_err <= 1'b0;
        end else begin
            byte_ready <= (state_d == S_COLLECT);
            report_err <= (state_d == S_COMMIT) &&
                          (err_flag || (state_q == S_SCAN && cur_slot == 8'h01));
        end
    end

    // Byte capture; modifier and reserved bytes are counted but not stored.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            byte_idx <= '0;
            slots    <= '0;
        end else if (state_q == S_COMMIT) begin
            byte_idx <= '0;
        end else if (state_q == S_COLLECT && xfer) begin
            byte_idx <= byte_idx + 1'b1;
            for (int s = 0; s < NUM_SLOTS; s++)
                if (byte_idx == IDX_W'(s + 2)) slots[s] <= byte_in;
        end
    end

    // Slot scan: first matching key per player wins, 0x01 flags rollover.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scan_idx <= '0;
            cand_p1  <= 8'h00;
            cand_p2  <= 8'h00;
            found_p1 <= 1'b0;
            found_p2 <= 1'b0;
            err_flag <= 1'b0;
        end else if (state_q == S_SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if (!found_p1 && is_p1_key(cur_slot)) begin
                cand_p1  <= cur_slot;
                found_p1 <= 1'b1;
            end
            if (!found_p2 && is_p2_key(cur_slot)) begin
                cand_p2  <= cur_slot;
                found_p2 <= 1'b1;
            end
            if (cur_slot == 8'h01) err_flag <= 1'b1;
        end else if (state_q == S_COLLECT) begin
            scan_idx <= '0;
            cand_p1  <= 8'h00;
            cand_p2  <= 8'h00;
            found_p1 <= 1'b0;
            found_p2 <= 1'b0;
            err_flag <= 1'b0;
        end
    end

    generate
        if (FRAME_SYNC) begin : g_frame
            logic [SYNC_STAGES:0] sync_pipe;  // top bit is the edge-detect flop
            logic                 frame_tick;
            logic [7:0]           pending_p1, pending_p2;

            // Pending keycodes; a rollover report leaves them untouched.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    pending_p1 <= 8'h00;
                    pending_p2 <= 8'h00;
                end else if (state_q == S_COMMIT && !err_flag) begin
                    pending_p1 <= cand_p1;
                    pending_p2 <= cand_p2;
                end
            end

            // frame_clk synchronizer plus registered rising-edge tick.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    sync_pipe  <= '0;
                    frame_tick <= 1'b0;
                end else begin
                    sync_pipe  <= {sync_pipe[SYNC_STAGES-1:0], frame_clk};
                    frame_tick <= sync_pipe[SYNC_STAGES-1] & ~sync_pipe[SYNC_STAGES];
                end
            end

            // Outputs follow pending on the tick; a same-cycle commit lands next frame.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    keycode_p1 <= 8'h00;
                    keycode_p2 <= 8'h00;
                end else if (frame_tick) begin
                    keycode_p1 <= pending_p1;
                    keycode_p2 <= pending_p2;
                end
            end
        end else begin : g_direct
            // Outputs load straight from the scan result at commit.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    keycode_p1 <= 8'h00;
                    keycode_p2 <= 8'h00;
                end else if (state_q == S_COMMIT && !err_flag) begin
                    keycode_p1 <= cand_p1;
                    keycode_p2 <= cand_p2;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_hid_key_router.sv
// Bench for hid_key_router: table of reports with expected keycodes pushed to
// a scoreboard on send and popped when a frame edge updates the outputs,
// plus hand sequences for mid-report reset and commit/frame collision.
module tb_hid_key_router;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode_p1, keycode_p2;
    logic       report_err;

    hid_key_router dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .frame_clk  (frame_clk),
        .keycode_p1 (keycode_p1),
        .keycode_p2 (keycode_p2),
        .report_err (report_err)
    );

    always #5 Clk = ~Clk;

    typedef logic [7:0][7:0] report_t;

    typedef struct {
        report_t    bytes;
        bit         gaps;
        bit         junk;
        bit         err;
        logic [7:0] p1;
        logic [7:0] p2;
    } vec_t;

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
    } exp_t;

    int         checks = 0;
    int         failures = 0;
    exp_t       sb[$];
    logic [7:0] cur_p1 = 8'h00;
    logic [7:0] cur_p2 = 8'h00;
    vec_t       tbl[5];

    function automatic report_t mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        report_t r;
        r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3;
        r[4] = b4; r[5] = b5; r[6] = b6; r[7] = b7;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive n bytes with optional random idle cycles; returns #1 after the last transfer edge.
    task automatic send_bytes(input report_t b, input int n, input bit gaps);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                byte_valid = 1'b0;
                @(posedge Clk); #1;
            end
            byte_valid = 1'b1;
            byte_in    = b[i];
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge Clk);
                if (byte_ready) begin ok = 1'b1; break; end
            end
            if (!ok) chk("ready_timeout", 32'd0, 32'd1);
            @(posedge Clk); #1;
        end
        byte_valid = 1'b0;
    endtask

    // Count back-pressure cycles after the last byte, optionally offering a junk byte.
    task automatic gap_check(input bit junk, input bit exp_err);
        int low, errs;
        low = 0; errs = 0;
        if (junk) begin byte_valid = 1'b1; byte_in = 8'h16; end
        for (int t = 0; t < 20; t++) begin
            @(negedge Clk);
            if (byte_ready) break;
            low++;
            if (report_err) errs++;
        end
        byte_valid = 1'b0;
        chk("ready_low_cycles", low, 7);
        chk("report_err_pulses", errs, {31'd0, exp_err});
        chk("p1_held_until_frame", keycode_p1, cur_p1);
        chk("p2_held_until_frame", keycode_p2, cur_p2);
    endtask

    // Frame pulse: outputs must hold through edge 2 and update at edge 3 after sampling.
    task automatic frame_pulse();
        exp_t e;
        @(posedge Clk); #1;
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("pre_edge_p1", keycode_p1, cur_p1);
        chk("pre_edge_p2", keycode_p2, cur_p2);
        @(posedge Clk); #1;
        frame_clk = 1'b0;
        @(negedge Clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("frame_p1", keycode_p1, e.p1);
            chk("frame_p2", keycode_p2, e.p2);
            cur_p1 = e.p1;
            cur_p2 = e.p2;
        end
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{mk(8'h00,8'h00,8'h1A,8'h00,8'h00,8'h00,8'h00,8'h00), 1'b0, 1'b0, 1'b0, 8'h1A, 8'h00};
        tbl[1] = '{mk(8'h02,8'h00,8'h51,8'h07,8'h04,8'h4F,8'h00,8'h00), 1'b0, 1'b0, 1'b0, 8'h07, 8'h51};
        tbl[2] = '{mk(8'h00,8'h00,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01), 1'b0, 1'b1, 1'b1, 8'h07, 8'h51};
        tbl[3] = '{mk(8'h05,8'h00,8'h29,8'h00,8'h00,8'h00,8'h51,8'h16), 1'b1, 1'b1, 1'b0, 8'h16, 8'h51};
        tbl[4] = '{mk(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_ready", byte_ready, 1'b0);
        chk("reset_p1", keycode_p1, 8'h00);
        chk("reset_p2", keycode_p2, 8'h00);
        chk("reset_err", report_err, 1'b0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Table-driven reports
        for (int i = 0; i < 5; i++) begin
            send_bytes(tbl[i].bytes, 8, tbl[i].gaps);
            sb.push_back('{tbl[i].p1, tbl[i].p2});
            gap_check(tbl[i].junk, tbl[i].err);
            frame_pulse();
        end

        // Reset mid-report: partial bytes must not leak into the next report
        send_bytes(mk(8'h00,8'h00,8'h16,8'h50,8'h00,8'h00,8'h00,8'h00), 4, 1'b0);
        Reset_n = 1'b0;
        #2;
        chk("midreset_ready", byte_ready, 1'b0);
        chk("midreset_p1", keycode_p1, 8'h00);
        chk("midreset_p2", keycode_p2, 8'h00);
        cur_p1 = 8'h00;
        cur_p2 = 8'h00;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        send_bytes(mk(8'h00,8'h00,8'h04,8'h52,8'h00,8'h00,8'h00,8'h00), 8, 1'b0);
        sb.push_back('{8'h04, 8'h52});
        gap_check(1'b0, 1'b0);
        frame_pulse();

        // Commit coinciding with the output-load edge
        send_bytes(mk(8'h00,8'h00,8'h16,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 1'b0);
        sb.push_back('{8'h16, 8'h00});
        gap_check(1'b0, 1'b0);
        frame_pulse();
        send_bytes(mk(8'h00,8'h00,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00), 8, 1'b0);
        // last byte at edge T; pending loads at T+7, so frame is sampled at T+4
        repeat (3) @(posedge Clk);
        #1 frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        chk("collide_p1_holds_old", keycode_p1, 8'h16);
        chk("collide_ready_back", byte_ready, 1'b1);
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        sb.push_back('{8'h04, 8'h00});
        frame_pulse();

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
